// File: rtl/pc_pkg.sv
// Shared types and helpers for the front-end program-counter generator.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } pc_state_e;

    typedef enum logic {
        RD_BRANCH = 1'b0,
        RD_TRAP   = 1'b1
    } rd_kind_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

    // Compressed ISA only needs halfword alignment; base ISA needs word alignment.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic c_ext);
        return c_ext ? addr_lo[0] : (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Pending-redirect register: holds one target raised during a stall.
// A trap may replace any pending entry; a branch only fills an empty buffer.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear_i,
    input  logic            load_i,
    input  rd_kind_e        load_kind_i,
    input  logic [XLEN-1:0] load_pc_i,
    output logic            valid_o,
    output rd_kind_e        kind_o,
    output logic [XLEN-1:0] pc_o
);

    logic            valid_q, valid_d;
    rd_kind_e        kind_q, kind_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            accept;

    assign accept = load_i && (!valid_q || (load_kind_i == RD_TRAP));

    always_comb begin
        valid_d = valid_q;
        kind_d  = kind_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
            kind_d  = RD_BRANCH;
            pc_d    = '0;
        end else if (accept) begin
            valid_d = 1'b1;
            kind_d  = load_kind_i;
            pc_d    = load_pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            kind_q  <= RD_BRANCH;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            kind_q  <= kind_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign kind_o  = kind_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: sequential fetch, prioritised trap/branch redirect,
// stall-deferred redirects and misaligned-branch rejection.
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
    parameter bit              C_EXT        = 1'b0,
    parameter int unsigned     INC          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            hazardpc_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_pc_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            run_q, run_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_pc_q, misalign_pc_d;

    logic            buf_clear, buf_load;
    rd_kind_e        buf_load_kind;
    logic [XLEN-1:0] buf_load_pc;
    logic            buf_valid;
    rd_kind_e        buf_kind;
    logic [XLEN-1:0] buf_pc;

    // Trap target wins whenever both requests arrive together.
    assign buf_load_kind = trap_i ? RD_TRAP : RD_BRANCH;
    assign buf_load_pc   = trap_i ? trap_vec_i : redirect_pc_i;

    pc_redirect_buf #(
        .XLEN (XLEN)
    ) u_redirect_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (buf_clear),
        .load_i      (buf_load),
        .load_kind_i (buf_load_kind),
        .load_pc_i   (buf_load_pc),
        .valid_o     (buf_valid),
        .kind_o      (buf_kind),
        .pc_o        (buf_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        run_d         = run_q;
        misalign_d    = 1'b0;
        misalign_pc_d = misalign_pc_q;
        buf_clear     = 1'b0;
        buf_load      = 1'b0;
        unique case (state_q)
            BOOT: begin
                run_d   = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (hazardpc_i) begin
                    if (trap_i || redirect_valid_i) begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end else if (trap_i) begin
                    pc_d = trap_vec_i;
                end else if (redirect_valid_i) begin
                    if (is_misaligned(redirect_pc_i[1:0], C_EXT)) begin
                        misalign_d    = 1'b1;
                        misalign_pc_d = redirect_pc_i;
                    end else begin
                        pc_d = redirect_pc_i;
                    end
                end else begin
                    pc_d = pc_q + XLEN'(INC);
                end
            end
            HOLD: begin
                if (hazardpc_i) begin
                    // Buffer itself discards a branch arriving over a pending entry.
                    buf_load = trap_i || redirect_valid_i;
                end else begin
                    buf_clear = 1'b1;
                    state_d   = RUN;
                    if (trap_i) begin
                        pc_d = trap_vec_i;
                    end else if (!buf_valid || (buf_kind == RD_TRAP)) begin
                        pc_d = buf_pc;
                    end else if (is_misaligned(buf_pc[1:0], C_EXT)) begin
                        misalign_d    = 1'b1;
                        misalign_pc_d = buf_pc;
                    end else begin
                        pc_d = buf_pc;
                    end
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            run_q         <= 1'b0;
            misalign_q    <= 1'b0;
            misalign_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            run_q         <= run_d;
            misalign_q    <= misalign_d;
            misalign_pc_q <= misalign_pc_d;
        end
    end

    // Fetch is suppressed combinationally by a live stall.
    assign pc_valid_o    = run_q && !hazardpc_i && !misalign_q;
    assign pc_o          = pc_q;
    assign misalign_o    = misalign_q;
    assign misalign_pc_o = misalign_pc_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; a second instance covers C_EXT=1.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        hazardpc_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        trap_i;
    logic [31:0] trap_vec_i;

    logic [31:0] pc_o,  pc_c;
    logic        pc_valid_o, pc_valid_c;
    logic        misalign_o, misalign_c;
    logic [31:0] misalign_pc_o, misalign_pc_c;

    int checks   = 0;
    int failures = 0;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b0), .INC(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .hazardpc_i       (hazardpc_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_i           (trap_i),
        .trap_vec_i       (trap_vec_i),
        .pc_o             (pc_o),
        .pc_valid_o       (pc_valid_o),
        .misalign_o       (misalign_o),
        .misalign_pc_o    (misalign_pc_o)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .C_EXT(1'b1), .INC(4)) dut_c (
        .clk              (clk),
        .rst_n            (rst_n),
        .hazardpc_i       (hazardpc_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_i           (trap_i),
        .trap_vec_i       (trap_vec_i),
        .pc_o             (pc_c),
        .pc_valid_o       (pc_valid_c),
        .misalign_o       (misalign_c),
        .misalign_pc_o    (misalign_pc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hazardpc_i       = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        trap_i           = 1'b0;
        trap_vec_i       = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc_o, 32'h0); end
        checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pc_valid_o); end
        checks++; if (misalign_o !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign_o); end
        checks++; if (misalign_pc_o !== 32'h0) begin failures++; $display("FAIL reset_misalign_pc got=%h exp=0", misalign_pc_o); end
        rst_n = 1'b1;
        #1;
        checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL boot_valid got=%b exp=0", pc_valid_o); end
        tick();
        checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin failures++; $display("FAIL first_fetch pc=%h valid=%b exp pc=0 valid=1", pc_o, pc_valid_o); end
        tick();
        checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL seq_4 got=%h exp=4", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h8 || pc_valid_o !== 1'b1) begin failures++; $display("FAIL seq_8 pc=%h valid=%b exp pc=8 valid=1", pc_o, pc_valid_o); end
    endtask

    task automatic test_redirect();
        tick();
        tick();
        checks++; if (pc_o !== 32'h10) begin failures++; $display("FAIL seq_10 got=%h exp=10", pc_o); end
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        checks++; if (pc_o !== 32'h200) begin failures++; $display("FAIL redirect_200 got=%h exp=200", pc_o); end
        redirect_valid_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'h204) begin failures++; $display("FAIL after_redirect got=%h exp=204", pc_o); end
    endtask

    task automatic test_stall_trap();
        hazardpc_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h300;
        #1;
        checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL stall_valid got=%b exp=0", pc_valid_o); end
        tick();
        redirect_valid_i = 1'b0; trap_i = 1'b1; trap_vec_i = 32'h80;
        tick();
        trap_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'h204) begin failures++; $display("FAIL stall_hold got=%h exp=204", pc_o); end
        hazardpc_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'h80) begin failures++; $display("FAIL pending_trap got=%h exp=80", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h84) begin failures++; $display("FAIL after_trap got=%h exp=84", pc_o); end
    endtask

    task automatic test_back_to_back();
        hazardpc_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h400;
        tick();
        redirect_pc_i = 32'h500;
        tick();
        checks++; if (pc_o !== 32'h84) begin failures++; $display("FAIL b2b_hold got=%h exp=84", pc_o); end
        hazardpc_i = 1'b0; redirect_valid_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'h400) begin failures++; $display("FAIL older_branch got=%h exp=400", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h404) begin failures++; $display("FAIL after_branch got=%h exp=404", pc_o); end
    endtask

    task automatic test_priority();
        trap_i = 1'b1; trap_vec_i = 32'h80; redirect_valid_i = 1'b1; redirect_pc_i = 32'h200;
        tick();
        checks++; if (pc_o !== 32'h80) begin failures++; $display("FAIL trap_over_branch got=%h exp=80", pc_o); end
        // Stalled branch pending, released with a live trap that must win.
        trap_i = 1'b0; hazardpc_i = 1'b1; redirect_pc_i = 32'h700;
        tick();
        hazardpc_i = 1'b0; redirect_valid_i = 1'b0; trap_i = 1'b1; trap_vec_i = 32'hC0;
        tick();
        trap_i = 1'b0;
        checks++; if (pc_o !== 32'hC0) begin failures++; $display("FAIL live_trap_release got=%h exp=c0", pc_o); end
        tick();
        tick();
        checks++; if (pc_o !== 32'hC8) begin failures++; $display("FAIL after_live_trap got=%h exp=c8", pc_o); end
    endtask

    task automatic test_misalign();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h102;
        tick();
        redirect_valid_i = 1'b0;
        checks++; if (pc_o !== 32'hC8) begin failures++; $display("FAIL misalign_hold got=%h exp=c8", pc_o); end
        checks++; if (misalign_o !== 1'b1 || misalign_pc_o !== 32'h102) begin failures++; $display("FAIL misalign_pulse got=%b/%h exp=1/102", misalign_o, misalign_pc_o); end
        checks++; if (pc_valid_o !== 1'b0) begin failures++; $display("FAIL misalign_valid got=%b exp=0", pc_valid_o); end
        checks++; if (pc_c !== 32'h102 || misalign_c !== 1'b0) begin failures++; $display("FAIL cext_redirect got=%h/%b exp=102/0", pc_c, misalign_c); end
        tick();
        checks++; if (misalign_o !== 1'b0 || misalign_pc_o !== 32'h102 || pc_o !== 32'hCC) begin failures++; $display("FAIL misalign_end got=%b/%h pc=%h exp=0/102 pc=cc", misalign_o, misalign_pc_o, pc_o); end
        hazardpc_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h3;
        tick();
        hazardpc_i = 1'b0; redirect_valid_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'hCC || misalign_o !== 1'b1 || misalign_pc_o !== 32'h3) begin failures++; $display("FAIL pending_misalign pc=%h mis=%b/%h exp pc=cc mis=1/3", pc_o, misalign_o, misalign_pc_o); end
        tick();
        checks++; if (pc_o !== 32'hD0 || misalign_o !== 1'b0) begin failures++; $display("FAIL after_pending_misalign pc=%h mis=%b exp pc=d0 mis=0", pc_o, misalign_o); end
    endtask

    task automatic test_wrap();
        redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        tick();
        redirect_valid_i = 1'b0;
        tick();
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("FAIL pre_wrap got=%h exp=fffffffc", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h0) begin failures++; $display("FAIL wrap got=%h exp=0", pc_o); end
        tick();
        checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL post_wrap got=%h exp=4", pc_o); end
    endtask

    task automatic test_reset_mid_hold();
        hazardpc_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 32'h600;
        tick();
        redirect_valid_i = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b0) begin failures++; $display("FAIL async_reset pc=%h valid=%b exp pc=0 valid=0", pc_o, pc_valid_o); end
        #10;
        hazardpc_i = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin failures++; $display("FAIL reboot pc=%h valid=%b exp pc=0 valid=1", pc_o, pc_valid_o); end
        tick();
        checks++; if (pc_o !== 32'h4) begin failures++; $display("FAIL pending_lost got=%h exp=4", pc_o); end
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_stall_trap();
        test_back_to_back();
        test_priority();
        test_misalign();
        test_wrap();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
